// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one synchronous-read memory port: VGA (V) reads have
// priority, and a starvation counter lets the CPU (C) through after STARVE_LIMIT V grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  v_req,
  input  logic [ADDR_WIDTH-1:0] v_addr,
  output logic                  v_gnt,
  output logic                  v_rvalid,
  output logic [DATA_WIDTH-1:0] v_rdata,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_V    = 2'd1,
    OWN_C    = 2'd2
  } owner_e;

  owner_e                  owner_q, owner_d;
  logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;

  // Grant selection, port drive and next-state computation
  always_comb begin
    v_gnt        = 1'b0;
    c_gnt        = 1'b0;
    mem_addr_d   = mem_addr_q;
    owner_d      = OWN_NONE;
    starve_cnt_d = starve_cnt_q;

    if (!reset) begin
      if (v_req && (!c_req || (starve_cnt_q < LIMIT))) begin
        v_gnt = 1'b1;
      end else if (c_req) begin
        c_gnt = 1'b1;
      end
    end

    if (v_gnt) begin
      mem_addr_d = v_addr;
      owner_d    = OWN_V;
    end else if (c_gnt) begin
      mem_addr_d = c_addr;
      owner_d    = c_we ? OWN_NONE : OWN_C;
    end

    // Count V grants that made a waiting CPU request wait; saturate at the limit
    if (c_gnt || !c_req) begin
      starve_cnt_d = '0;
    end else if (v_gnt && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  assign mem_addr  = mem_addr_d;
  assign mem_we    = c_gnt & c_we;
  assign mem_wdata = c_wdata;

  // Read return: owner of the previous cycle's read; suppressed while in reset
  assign v_rvalid = (owner_q == OWN_V) & ~reset;
  assign c_rvalid = (owner_q == OWN_C) & ~reset;
  assign v_rdata  = mem_rdata;
  assign c_rdata  = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      owner_q      <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
    end
    mem_addr_q <= mem_addr_d;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level model of the arbitration rules and a reference memory.
module tb_mem_port_arbiter;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          v_req, v_gnt, v_rvalid;
  logic [AW-1:0] v_addr;
  logic [DW-1:0] v_rdata;
  logic          c_req, c_we, c_gnt, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .v_req(v_req), .v_addr(v_addr), .v_gnt(v_gnt), .v_rvalid(v_rvalid), .v_rdata(v_rdata),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory attached to the port
  logic [DW-1:0] mem [0:65535];
  initial for (int i = 0; i < 65536; i++) mem[i] = DW'(i) ^ 16'hA5A5;
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Reference model state
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            m_waits = 0;
  logic          m_pend_v = 1'b0, m_pend_c = 1'b0;
  logic [DW-1:0] m_pend_data = '0;
  logic [AW-1:0] m_last_addr = '0;
  logic          m_last_valid = 1'b0;

  logic          exp_vg, exp_cg, exp_we, exp_vrv, exp_crv, exp_addr_valid;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_rdata;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 16'hA5A5;
  endfunction

  task automatic model_eval();
    exp_vg = 1'b0;
    exp_cg = 1'b0;
    if (!reset) begin
      if (v_req && c_req) begin
        if (m_waits < int'(LIMIT)) exp_vg = 1'b1;
        else exp_cg = 1'b1;
      end else if (v_req) exp_vg = 1'b1;
      else if (c_req) exp_cg = 1'b1;
    end
    exp_we = exp_cg && c_we;
    exp_addr_valid = exp_vg || exp_cg || m_last_valid;
    exp_addr = exp_vg ? v_addr : (exp_cg ? c_addr : m_last_addr);
    exp_vrv = m_pend_v && !reset;
    exp_crv = m_pend_c && !reset;
    exp_rdata = m_pend_data;
  endtask

  task automatic model_commit();
    if (exp_vg || exp_cg) begin
      m_last_addr  = exp_addr;
      m_last_valid = 1'b1;
    end
    if (reset) begin
      m_waits  = 0;
      m_pend_v = 1'b0;
      m_pend_c = 1'b0;
    end else begin
      if (exp_vg && c_req) m_waits = (m_waits < int'(LIMIT)) ? m_waits + 1 : int'(LIMIT);
      else m_waits = 0;
      m_pend_v = exp_vg;
      m_pend_c = exp_cg && !c_we;
      if (m_pend_v || m_pend_c) m_pend_data = ref_rd(exp_addr);
      if (exp_we) ref_mem[c_addr] = c_wdata;
    end
  endtask

  task automatic drive(input logic r, input logic vr, input logic [AW-1:0] va,
                       input logic cr, input logic we, input logic [AW-1:0] ca,
                       input logic [DW-1:0] wd);
    reset = r; v_req = vr; v_addr = va;
    c_req = cr; c_we = we; c_addr = ca; c_wdata = wd;
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h0050, 16'h1234);
      checks++; if (v_gnt !== 1'b0) begin errors++; $display("FAIL reset_v_gnt: got %b want 0", v_gnt); end
      checks++; if (c_gnt !== 1'b0) begin errors++; $display("FAIL reset_c_gnt: got %b want 0", c_gnt); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
      checks++; if ({v_rvalid, c_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {v_rvalid, c_rvalid}); end
      advance();
    end
    drive(1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0050, 16'h0000);
    checks++; if ({v_gnt, c_gnt} !== 2'b10) begin errors++; $display("FAIL reset_first_grant: got %b want 10", {v_gnt, c_gnt}); end
    checks++; if (mem_addr !== 16'h0040) begin errors++; $display("FAIL reset_first_addr: got %h want 0040", mem_addr); end
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checks++; if (v_rvalid !== 1'b1) begin errors++; $display("FAIL reset_first_rvalid: got %b want 1", v_rvalid); end
    checks++; if (v_rdata !== (16'h0040 ^ 16'hA5A5)) begin errors++; $display("FAIL reset_first_rdata: got %h want %h", v_rdata, 16'h0040 ^ 16'hA5A5); end
    advance();
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    checks++; if ({v_gnt, c_gnt} !== 2'b01) begin errors++; $display("FAIL wr_grant: got %b want 01", {v_gnt, c_gnt}); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we: got %b want 1", mem_we); end
    checks++; if ({mem_addr, mem_wdata} !== {16'h0010, 16'hBEEF}) begin errors++; $display("FAIL wr_port: got %h/%h want 0010/beef", mem_addr, mem_wdata); end
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000);
    checks++; if ({c_gnt, mem_we} !== 2'b10) begin errors++; $display("FAIL rd_grant: got %b want 10", {c_gnt, mem_we}); end
    checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b want 0", c_rvalid); end
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checks++; if ({v_rvalid, c_rvalid} !== 2'b01) begin errors++; $display("FAIL rd_rvalid: got %b want 01", {v_rvalid, c_rvalid}); end
    checks++; if (c_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h want beef", c_rdata); end
    advance();
  endtask

  task automatic test_starvation();
    string pattern = "VVVVCVVVVCVV";
    string got;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0200, 16'h0000);
      got = v_gnt ? "V" : (c_gnt ? "C" : "-");
      checks++; if (got != pattern.substr(i, i)) begin errors++; $display("FAIL starve_grant[%0d]: got %s want %s", i, got, pattern.substr(i, i)); end
      checks++; if ((v_gnt & c_gnt) !== 1'b0) begin errors++; $display("FAIL starve_exclusive[%0d]: got both granted want one", i); end
      checks++; if ({v_rvalid, c_rvalid} !== {exp_vrv, exp_crv}) begin errors++; $display("FAIL starve_rvalid[%0d]: got %b want %b", i, {v_rvalid, c_rvalid}, {exp_vrv, exp_crv}); end
      advance();
    end
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) drive(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000);
      else            drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
      if (i > 0) begin
        checks++; if ({v_rvalid, c_rvalid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_rvalid[%0d]: got %b", i, {v_rvalid, c_rvalid}); end
        checks++; if (v_rdata !== ref_rd((i % 2 == 1) ? 16'h0001 : 16'h0002)) begin errors++; $display("FAIL alt_rdata[%0d]: got %h want %h", i, v_rdata, ref_rd((i % 2 == 1) ? 16'h0001 : 16'h0002)); end
      end
      advance();
    end
  endtask

  task automatic test_reset_after_read();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000);
    checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL rar_grant: got %b want 1", c_gnt); end
    advance();
    drive(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000);
    checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL rar_rvalid_in_reset: got %b want 0", c_rvalid); end
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checks++; if ({v_rvalid, c_rvalid} !== 2'b00) begin errors++; $display("FAIL rar_rvalid_after: got %b want 00", {v_rvalid, c_rvalid}); end
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h0006, 16'h0000);
      checks++; if ({v_gnt, c_gnt} !== ((i == 4) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rar_count_clear[%0d]: got %b", i, {v_gnt, c_gnt}); end
      advance();
    end
  endtask

  task automatic test_cancel();
    int first_c = -1;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 16'h0300, (i < 3), 1'b0, 16'h0400, 16'h0000);
      checks++; if (c_gnt !== 1'b0) begin errors++; $display("FAIL cancel_no_cgnt[%0d]: got %b want 0", i, c_gnt); end
      advance();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 16'h0300, 1'b1, 1'b0, 16'h0401, 16'h0000);
      if (c_gnt === 1'b1 && first_c < 0) first_c = i;
      advance();
    end
    checks++; if (first_c != 4) begin errors++; $display("FAIL cancel_count_clear: got first C grant at %0d want 4", first_c); end
  endtask

  task automatic test_random();
    logic vr = 1'b0, cr = 1'b0, cwe = 1'b0, rst;
    logic [AW-1:0] va = '0, ca = '0;
    logic [DW-1:0] cwd = '0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(rst, vr, va, cr, cwe, ca, cwd);
      checks++; if ({v_gnt, c_gnt, mem_we} !== {exp_vg, exp_cg, exp_we}) begin errors++; $display("FAIL rnd_grant[%0d]: got %b want %b", i, {v_gnt, c_gnt, mem_we}, {exp_vg, exp_cg, exp_we}); end
      checks++; if (mem_wdata !== c_wdata) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, mem_wdata, c_wdata); end
      if (exp_addr_valid) begin
        checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, mem_addr, exp_addr); end
      end
      checks++; if ({v_rvalid, c_rvalid} !== {exp_vrv, exp_crv}) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", i, {v_rvalid, c_rvalid}, {exp_vrv, exp_crv}); end
      if (exp_vrv || exp_crv) begin
        checks++; if ((exp_vrv ? v_rdata : c_rdata) !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, exp_vrv ? v_rdata : c_rdata, exp_rdata); end
      end
      advance();
      if (!vr || exp_vg) begin
        vr = ($urandom_range(0, 3) != 0);
        va = AW'($urandom_range(0, 15));
      end else if ($urandom_range(0, 7) == 0) vr = 1'b0;
      if (!cr || exp_cg) begin
        cr  = ($urandom_range(0, 2) != 0);
        cwe = ($urandom_range(0, 1) != 0);
        ca  = AW'($urandom_range(0, 15));
        cwd = DW'($urandom);
      end else if ($urandom_range(0, 7) == 0) cr = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; v_req = 1'b0; v_addr = '0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_starvation();
    test_alternate();
    test_reset_after_read();
    test_cancel();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
